cam_param: RTL and testbench
============================

# cam_param

Parametrised content-addressable memory: DEPTH entries of DATA_W bits, each with a valid bit. It supports masked search, priority-encoded hit address, a multi-hit flag, per-entry invalidate, a single-cycle flush and an occupancy counter. It replaces the fixed 8-bit/32-entry cam as the lookup table in the tiny_brent_kung datapath, where duplicate detection and entry retirement are required.

## Interface
- DATA_W, 8, entry/key width in bits (≥1)
- DEPTH, 32, number of entries (≥2, need not be a power of two)
- ADDR_W, $clog2(DEPTH), entry index width (derived; not overridden)
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- en  input  1  operation strobe; 0 = idle, no state change
- op  input  2  00 search, 01 write, 10 invalidate, 11 flush
- addr  input  ADDR_W  entry index for write/invalidate
- data  input  DATA_W  write data or search key
- mask  input  DATA_W  search compare mask; bit=1 compares, bit=0 is don't-care
- out  output  ADDR_W  lowest matching entry index from last search
- found  output  1  last search hit at least one valid entry
- multi  output  1  last search hit two or more valid entries
- count  output  ADDR_W+1  number of valid entries

## Operation
- Storage: DEPTH×DATA_W data array plus DEPTH valid bits. Data array is not reset; valid bits gate all matching.
- Entry i matches when valid[i] and ((stored[i] ^ data) & mask) == 0.
- Search (en=1, op=00): matches are evaluated against state as it stood before the edge. found = OR of matches. out = lowest matching index, or 0 when found=0. multi = more than one match.
- Write (en=1, op=01): stored[addr]←data, valid[addr]←1. count increments only if the entry was previously invalid. Overwriting a valid entry leaves count unchanged.
- Invalidate (en=1, op=10): valid[addr]←0. count decrements only if the entry was valid. An invalid target is a no-op.
- Flush (op=11): all valid←0, count←0.
- addr ≥ DEPTH on write/invalidate: operation ignored, no state change.
- out/found/multi change only on a search or a reset. Write, invalidate, flush and en=0 leave them unchanged, even if the held result is now stale.
- Duplicate data is allowed. A search reports the lowest index with multi=1.
- mask=0: every valid entry matches; found=(count≠0).
- count never exceeds DEPTH and never underflows.

## Timing
- Reset: rst sampled high at an edge clears all valid bits and sets count=0, out=0, found=0, multi=0. rst overrides en/op in the same cycle. Reset mid-operation discards that operation.
- Search latency: one cycle. Key presented before edge N; out/found/multi are valid after edge N and held until the next search edge or reset.
- Write/invalidate/flush commit at edge N. A search sampled at edge N+1 sees the result. A search at edge N is impossible because op is single-valued.
- Back-to-back operations of any kind at full clock rate; no stall or busy signal.
- count updates at the same edge as the valid-bit change.
- Priority encoder and match reduction are combinational into the output registers. No pipelining beyond the single output stage.

## Test plan
- Reset then fill: rst=1 for one edge. Write 0x10+i to addr i for i=0..31 -> count=32. Search 0x10..0x2F each -> found=1, multi=0, out=i one cycle later.
- Miss: search 0x00, 0xFF and 0x55 with mask=0xFF after the fill -> found=0, out=0, multi=0.
- Duplicates: write 0xAA to addrs 5, 10 and 20 (count stays 32). Search 0xAA -> found=1, out=5, multi=1. Invalidate 5, then search -> out=10, multi=1, count=31.
- Masked search: entries hold 0x10..0x2F. Search data=0x20 with mask=0xF0 -> out=16, multi=1. With mask=0x00 -> out=0, multi=1.
- Invalidate/flush/idle: invalidate an already-invalid addr -> count unchanged. Write to addr 31 then search -> out=31. Flush -> count=0 while out/found hold the old values. Next search 0x2F -> found=0. With en=0 and op toggling, no change anywhere.
- Reset mid-stream: assert rst in the same cycle as a write of 0x77 to addr 3. Then search 0x77 -> found=0, count=0, and out/found/multi=0 after the reset edge.

Source files
------------

// File: rtl/cam_param_if.sv
// Request/result bundle for the parametrised CAM: one operation in, one registered search result and occupancy out.
interface cam_param_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 32
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic              en;
    logic [1:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] mask;
    logic [ADDR_W-1:0] out;
    logic              found;
    logic              multi;
    logic [ADDR_W:0]   count;

    modport master (
        output en, op, addr, data, mask,
        input  out, found, multi, count
    );

    modport slave (
        input  en, op, addr, data, mask,
        output out, found, multi, count
    );
endinterface

// File: rtl/cam_param.sv
// Parametrised CAM: masked search with priority-encoded hit, multi-hit flag,
// per-entry invalidate, single-cycle flush and a valid-entry counter.
module cam_param #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 32
) (
    input  logic            clk,
    input  logic            rst,
    cam_param_if.slave      bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    localparam logic [1:0] OP_SEARCH = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_INVAL  = 2'b10;
    localparam logic [1:0] OP_FLUSH  = 2'b11;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [DEPTH-1:0]  valid_nxt;
    logic [DEPTH-1:0]  match;
    logic [ADDR_W-1:0] hit_idx;
    logic              hit_any;
    logic              hit_many;
    logic              addr_ok;
    logic              tgt_valid;
    logic              do_write;
    logic              do_search;
    logic [CNT_W-1:0]  count_nxt;

    // Per-entry match against pre-edge contents; invalid entries never match.
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match[i] = valid[i] && (((mem[i] ^ bus.data) & bus.mask) == '0);
        end
    end

    // Lowest-index priority encode plus "seen a second hit" flag.
    always_comb begin
        hit_idx  = '0;
        hit_any  = 1'b0;
        hit_many = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (match[i]) begin
                if (hit_any) begin
                    hit_many = 1'b1;
                end else begin
                    hit_idx = ADDR_W'(i);
                end
                hit_any = 1'b1;
            end
        end
    end

    // Out-of-range targets (non power-of-two DEPTH) are dropped silently.
    always_comb begin
        addr_ok   = (32'(bus.addr) < DEPTH);
        tgt_valid = addr_ok ? valid[bus.addr] : 1'b0;
        do_search = bus.en && (bus.op == OP_SEARCH);
    end

    // Next valid vector and occupancy; count only moves on real valid-bit transitions.
    always_comb begin
        valid_nxt = valid;
        count_nxt = bus.count;
        do_write  = 1'b0;
        if (bus.en) begin
            case (bus.op)
                OP_WRITE: begin
                    if (addr_ok) begin
                        do_write             = 1'b1;
                        valid_nxt[bus.addr]  = 1'b1;
                        if (!tgt_valid) begin
                            count_nxt = bus.count + CNT_W'(1);
                        end
                    end
                end
                OP_INVAL: begin
                    if (tgt_valid) begin
                        valid_nxt[bus.addr] = 1'b0;
                        count_nxt           = bus.count - CNT_W'(1);
                    end
                end
                OP_FLUSH: begin
                    valid_nxt = '0;
                    count_nxt = '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Valid bits, occupancy and held search result.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= '0;
            bus.count <= '0;
            bus.out   <= '0;
            bus.found <= 1'b0;
            bus.multi <= 1'b0;
        end else begin
            valid     <= valid_nxt;
            bus.count <= count_nxt;
            if (do_search) begin
                bus.out   <= hit_idx;
                bus.found <= hit_any;
                bus.multi <= hit_many;
            end
        end
    end

    // Data array carries no reset; valid bits make its contents irrelevant until written.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            mem[bus.addr] <= bus.data;
        end
    end

endmodule

// File: tb/tb_cam_param.sv
// Bench for cam_param: directed scenarios with literal expectations, then random
// traffic compared every cycle against an array-based model.
module tb_cam_param;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cam_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    cam_param #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    logic [DATA_W-1:0] m_data [DEPTH];
    bit                m_valid [DEPTH];
    int                m_out   = 0;
    bit                m_found = 1'b0;
    bit                m_multi = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    function automatic int occupancy();
        int n = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (m_valid[i]) n++;
        return n;
    endfunction

    function automatic void model_search(input logic [DATA_W-1:0] key, input logic [DATA_W-1:0] msk,
                                         output int first, output int hits);
        first = 0;
        hits  = 0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (m_valid[i] && (((m_data[i] ^ key) & msk) == '0)) begin
                first = i;
                hits++;
            end
        end
    endfunction

    // Model: state as sets of entries, result recomputed by a linear scan.
    always @(posedge clk) begin
        int first;
        int hits;
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) m_valid[i] <= 1'b0;
            m_out   <= 0;
            m_found <= 1'b0;
            m_multi <= 1'b0;
        end else if (bus.en) begin
            case (bus.op)
                2'b00: begin
                    model_search(bus.data, bus.mask, first, hits);
                    m_out   <= first;
                    m_found <= (hits > 0);
                    m_multi <= (hits > 1);
                end
                2'b01: if (32'(bus.addr) < DEPTH) begin
                    m_data[bus.addr]  <= bus.data;
                    m_valid[bus.addr] <= 1'b1;
                end
                2'b10: if (32'(bus.addr) < DEPTH) m_valid[bus.addr] <= 1'b0;
                default: for (int i = 0; i < int'(DEPTH); i++) m_valid[i] <= 1'b0;
            endcase
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("out",   32'(bus.out),   32'(m_out));
            chk("found", 32'(bus.found), 32'(m_found));
            chk("multi", 32'(bus.multi), 32'(m_multi));
            chk("count", 32'(bus.count), 32'(occupancy()));
        end
    end

    task automatic cyc(input bit r, input bit e, input int o, input int a, input int d, input int m);
        @(negedge clk);
        rst      = r;
        bus.en   = e;
        bus.op   = 2'(o);
        bus.addr = ADDR_W'(a);
        bus.data = DATA_W'(d);
        bus.mask = DATA_W'(m);
        @(posedge clk);
        #1;
    endtask

    task automatic lit_res(input string name, input int o, input int f, input int mu);
        chk({name, ".out"},   32'(bus.out),   32'(o));
        chk({name, ".found"}, 32'(bus.found), 32'(f));
        chk({name, ".multi"}, 32'(bus.multi), 32'(mu));
    endtask

    initial begin
        bus.en   = 1'b0;
        bus.op   = 2'b00;
        bus.addr = '0;
        bus.data = '0;
        bus.mask = '0;

        // reset
        cyc(1, 0, 0, 0, 0, 0);
        chk_on = 1'b1;
        lit_res("reset", 0, 0, 0);
        chk("reset.count", 32'(bus.count), 0);

        // fill and exact searches
        for (int i = 0; i < 32; i++) cyc(0, 1, 1, i, 8'h10 + i, 0);
        chk("fill.count", 32'(bus.count), 32);
        for (int i = 0; i < 32; i++) begin
            cyc(0, 1, 0, 0, 8'h10 + i, 8'hFF);
            lit_res("hit", i, 1, 0);
        end

        // misses
        cyc(0, 1, 0, 0, 8'h00, 8'hFF); lit_res("miss00", 0, 0, 0);
        cyc(0, 1, 0, 0, 8'hFF, 8'hFF); lit_res("missFF", 0, 0, 0);
        cyc(0, 1, 0, 0, 8'h55, 8'hFF); lit_res("miss55", 0, 0, 0);

        // duplicates
        cyc(0, 1, 1, 5,  8'hAA, 0);
        cyc(0, 1, 1, 10, 8'hAA, 0);
        cyc(0, 1, 1, 20, 8'hAA, 0);
        chk("dup.count", 32'(bus.count), 32);
        cyc(0, 1, 0, 0, 8'hAA, 8'hFF); lit_res("dup", 5, 1, 1);
        cyc(0, 1, 2, 5, 0, 0);
        cyc(0, 1, 0, 0, 8'hAA, 8'hFF); lit_res("dup_inv", 10, 1, 1);
        chk("dup_inv.count", 32'(bus.count), 31);

        // masked searches
        cyc(0, 1, 0, 0, 8'h20, 8'hF0); lit_res("mask_f0", 16, 1, 1);
        cyc(0, 1, 0, 0, 8'h20, 8'h00); lit_res("mask_00", 0, 1, 1);

        // invalidate an invalid entry, write/search top, flush, idle
        cyc(0, 1, 2, 5, 0, 0);
        chk("inv_noop.count", 32'(bus.count), 31);
        cyc(0, 1, 1, 31, 8'h3C, 0);
        cyc(0, 1, 0, 0, 8'h3C, 8'hFF); lit_res("top", 31, 1, 0);
        cyc(0, 1, 3, 0, 0, 0);
        chk("flush.count", 32'(bus.count), 0);
        lit_res("flush_hold", 31, 1, 0);
        cyc(0, 1, 0, 0, 8'h2F, 8'hFF); lit_res("post_flush", 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, k, k, 8'h2F, 8'hFF);
            chk("idle.count", 32'(bus.count), 0);
            chk("idle.found", 32'(bus.found), 0);
        end

        // reset in the same cycle as a write
        cyc(0, 1, 1, 7, 8'h42, 0);
        cyc(0, 1, 0, 0, 8'h42, 8'hFF); lit_res("pre_rst", 7, 1, 0);
        cyc(1, 1, 1, 3, 8'h77, 8'hFF);
        lit_res("mid_rst", 0, 0, 0);
        chk("mid_rst.count", 32'(bus.count), 0);
        cyc(0, 1, 0, 0, 8'h77, 8'hFF); lit_res("after_rst", 0, 0, 0);
        chk("after_rst.count", 32'(bus.count), 0);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int v;
            int op;
            int msk;
            v   = int'($urandom_range(0, 19));
            op  = (v < 8) ? 0 : (v < 14) ? 1 : (v < 19) ? 2 : 3;
            msk = ($urandom_range(0, 3) == 0) ? 8'hFF : int'($urandom_range(0, 255));
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0), op,
                int'($urandom_range(0, 31)), int'($urandom_range(0, 15)), msk);
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
